// File: rtl/load_store_unit_if.sv
// Request and data-memory bus for the load/store unit.
// slave is the LSU side; master is the datapath/memory side that drives it.
interface load_store_unit_if #(
  parameter int ADDR_W = 11
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [3:0]        req_rd;
  logic [31:0]       req_str_data;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_load, req_byte, req_addr, req_rd, req_str_data,
    output req_ready,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_load, req_byte, req_addr, req_rd, req_str_data,
    input  req_ready,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// LDR/STR memory-access stage: one request at a time, data-memory handshake, regfile load writeback.
// Define LSU_BYTE_ACCESS_EN to enable LDRB/STRB byte-lane accesses; otherwise every access is a word.
module load_store_unit #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [DATA_W-1:0] w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

`ifdef LSU_BYTE_ACCESS_EN
  localparam int ADDR_LO = 0;
`else
  localparam int ADDR_LO = 2;
`endif

  state_t                  state_q, state_d;
  logic                    load_q, load_d;
  logic [ADDR_W+1:ADDR_LO] addr_q, addr_d;
  logic [3:0]              rd_q, rd_d;
  logic [31:0]             sdata_q, sdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    store_done_q, store_done_d;

`ifdef LSU_BYTE_ACCESS_EN
  logic                    byte_q, byte_d;

  function automatic logic [3:0] fmt_wstrb(input logic byte_acc, input logic [1:0] lane);
    return byte_acc ? (4'b0001 << lane) : 4'hF;
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic byte_acc, input logic [31:0] d);
    return byte_acc ? {4{d[7:0]}} : d;
  endfunction

  // Byte loads return the addressed little-endian lane, zero-extended.
  function automatic logic [31:0] fmt_rdata(input logic byte_acc, input logic [1:0] lane,
                                            input logic [31:0] d);
    return byte_acc ? {24'd0, d[{lane, 3'b000} +: 8]} : d;
  endfunction
`else
  function automatic logic [3:0] fmt_wstrb();
    return 4'hF;
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [31:0] d);
    return d;
  endfunction

  function automatic logic [31:0] fmt_rdata(input logic [31:0] d);
    return d;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    sdata_d      = sdata_q;
    rdata_d      = rdata_q;
    store_done_d = 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
    byte_d       = byte_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          load_d  = bus.req_load;
          addr_d  = bus.req_addr[ADDR_W+1:ADDR_LO];
          rd_d    = bus.req_rd;
          sdata_d = bus.req_str_data;
`ifdef LSU_BYTE_ACCESS_EN
          byte_d  = bus.req_byte;
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          if (load_q) begin
            state_d = WAIT_R;
          end else begin
            state_d      = IDLE;
            store_done_d = 1'b1;
          end
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid) begin
`ifdef LSU_BYTE_ACCESS_EN
          rdata_d = fmt_rdata(byte_q, addr_q[1:0], bus.mem_rdata);
`else
          rdata_d = fmt_rdata(bus.mem_rdata);
`endif
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fields are cleared on reset as well, so a stale access never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      addr_q       <= '0;
      rd_q         <= '0;
      sdata_q      <= '0;
      rdata_q      <= '0;
      store_done_q <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
      byte_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      sdata_q      <= sdata_d;
      rdata_q      <= rdata_d;
      store_done_q <= store_done_d;
`ifdef LSU_BYTE_ACCESS_EN
      byte_q       <= byte_d;
`endif
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge lands.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    w_en_ldr      = 1'b0;
    w_data_ldr    = '0;
    w_addr_ldr    = '0;
    busy          = 1'b0;
    done          = 1'b0;
    if (!rst) begin
      bus.req_ready = (state_q == IDLE);
      busy          = (state_q != IDLE);
      done          = (state_q == WB) || store_done_q;
      if (state_q == REQ) begin
        bus.mem_valid = 1'b1;
        bus.mem_wen   = !load_q;
        bus.mem_addr  = addr_q[ADDR_W+1:2];
`ifdef LSU_BYTE_ACCESS_EN
        bus.mem_wdata = fmt_wdata(byte_q, sdata_q);
        bus.mem_wstrb = fmt_wstrb(byte_q, addr_q[1:0]);
`else
        bus.mem_wdata = fmt_wdata(sdata_q);
        bus.mem_wstrb = fmt_wstrb();
`endif
      end
      if (state_q == WB) begin
        w_en_ldr   = 1'b1;
        w_data_ldr = rdata_q;
        w_addr_ldr = rd_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, word load/store, stall, reset abort, byte lanes, spurious rvalid.
module tb_load_store_unit;
  localparam int ADDR_W = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] w_data_ldr;
  logic [3:0]  w_addr_ldr;
  logic        w_en_ldr;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .w_data_ldr (w_data_ldr),
    .w_addr_ldr (w_addr_ldr),
    .w_en_ldr   (w_en_ldr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_load     = 1'b0;
    bus.req_byte     = 1'b0;
    bus.req_addr     = '0;
    bus.req_rd       = '0;
    bus.req_str_data = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  task automatic request(input logic ld, input logic byt, input logic [31:0] addr,
                         input logic [3:0] rd, input logic [31:0] sdata);
    bus.req_valid    = 1'b1;
    bus.req_load     = ld;
    bus.req_byte     = byt;
    bus.req_addr     = addr;
    bus.req_rd       = rd;
    bus.req_str_data = sdata;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Reset held two cycles with a request pending
    request(1'b1, 1'b0, 32'h10, 4'd3, 32'hFFFF_FFFF);
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_mem_valid", bus.mem_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_w_en", w_en_ldr, 0);
      check("rst_w_data", w_data_ldr, 0);
      check("rst_wstrb", bus.mem_wstrb, 0);
    end
    rst = 1'b0;
    idle_inputs();
    settle();
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_busy", busy, 0);

    // Word load, minimum latency
    request(1'b1, 1'b0, 32'h0000_0010, 4'd3, 32'h0);
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    settle();
    check("ld_mem_valid", bus.mem_valid, 1);
    check("ld_mem_addr", bus.mem_addr, 11'h004);
    check("ld_mem_wen", bus.mem_wen, 0);
    check("ld_req_ready", bus.req_ready, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    settle();
    check("ld_waitr_valid", bus.mem_valid, 0);
    check("ld_waitr_wen", w_en_ldr, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_ready  = 1'b0;
    settle();
    check("ld_w_en", w_en_ldr, 1);
    check("ld_w_addr", w_addr_ldr, 3);
    check("ld_w_data", w_data_ldr, 32'hDEAD_BEEF);
    check("ld_done", done, 1);
    tick();
    check("ld_w_en_end", w_en_ldr, 0);
    check("ld_w_data_end", w_data_ldr, 0);
    check("ld_done_end", done, 0);
    check("ld_ready_end", bus.req_ready, 1);

    // Word store, mem_ready low 3 cycles
    request(1'b0, 1'b0, 32'h20, 4'd7, 32'h1234_5678);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      settle();
      check("st_mem_valid", bus.mem_valid, 1);
      check("st_mem_addr", bus.mem_addr, 11'h008);
      check("st_mem_wen", bus.mem_wen, 1);
      check("st_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      check("st_mem_wstrb", bus.mem_wstrb, 4'hF);
      check("st_done_early", done, 0);
      check("st_w_en", w_en_ldr, 0);
      tick();
    end
    bus.mem_ready = 1'b0;
    settle();
    check("st_done", done, 1);
    check("st_valid_after", bus.mem_valid, 0);
    check("st_wen_after", bus.mem_wen, 0);
    check("st_wstrb_after", bus.mem_wstrb, 0);
    check("st_w_en_after", w_en_ldr, 0);
    tick();
    check("st_done_end", done, 0);

    // Reset while waiting for read data
    request(1'b1, 1'b0, 32'h40, 4'd5, 32'h0);
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("rm_busy", busy, 1);
    check("rm_valid", bus.mem_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    settle();
    check("rm_idle_busy", busy, 0);
    check("rm_idle_ready", bus.req_ready, 1);
    check("rm_w_en", w_en_ldr, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    check("rm_w_en2", w_en_ldr, 0);
    check("rm_done2", done, 0);
    check("rm_busy2", busy, 0);
    tick();
    check("rm_w_en3", w_en_ldr, 0);

    // Byte store / byte load
    request(1'b0, 1'b1, 32'h7, 4'd0, 32'h0000_00AB);
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    settle();
`ifdef LSU_BYTE_ACCESS_EN
    check("strb_wstrb", bus.mem_wstrb, 4'b1000);
    check("strb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
`else
    check("strb_wstrb", bus.mem_wstrb, 4'hF);
    check("strb_wdata", bus.mem_wdata, 32'h0000_00AB);
`endif
    check("strb_addr", bus.mem_addr, 11'h001);
    tick();
    check("strb_done", done, 1);
    request(1'b1, 1'b1, 32'h6, 4'd9, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11C3_2233;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_ready  = 1'b0;
    settle();
    check("ldrb_w_en", w_en_ldr, 1);
    check("ldrb_w_addr", w_addr_ldr, 9);
`ifdef LSU_BYTE_ACCESS_EN
    check("ldrb_w_data", w_data_ldr, 32'h0000_00C3);
`else
    check("ldrb_w_data", w_data_ldr, 32'h11C3_2233);
`endif
    tick();

    // Spurious rvalid in IDLE and REQ; r15 passes through
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    tick();
    check("sp_idle_busy", busy, 0);
    check("sp_idle_w_en", w_en_ldr, 0);
    request(1'b1, 1'b0, 32'h0000_0FFC, 4'd15, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("sp_req_valid", bus.mem_valid, 1);
      check("sp_req_w_en", w_en_ldr, 0);
      check("sp_req_addr", bus.mem_addr, 11'h3FF);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_ready  = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0055;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    check("sp_w_en", w_en_ldr, 1);
    check("sp_w_addr", w_addr_ldr, 15);
    check("sp_w_data", w_data_ldr, 32'h55);
    tick();
    check("sp_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
